// File: rtl/srambus2axi_master_pkg.sv
// Shared definitions for the SRAM-bus to AXI master bridge.
// Contents: one-hot FSM state encodings, AXI constant field values and a response-error helper.
// No ports; imported by srambus2axi_master.
package srambus2axi_master_pkg;

    // One-hot state encodings (5 bits).
    localparam logic [4:0] ST_IDLE_OH    = 5'b00001;
    localparam logic [4:0] ST_RD_ADDR_OH = 5'b00010;
    localparam logic [4:0] ST_RD_DATA_OH = 5'b00100;
    localparam logic [4:0] ST_WR_REQ_OH  = 5'b01000;
    localparam logic [4:0] ST_WR_RESP_OH = 5'b10000;

    typedef enum logic [4:0] {
        ST_IDLE    = ST_IDLE_OH,
        ST_RD_ADDR = ST_RD_ADDR_OH,
        ST_RD_DATA = ST_RD_DATA_OH,
        ST_WR_REQ  = ST_WR_REQ_OH,
        ST_WR_RESP = ST_WR_RESP_OH
    } state_e;

    // AXI constant field values.
    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // SLVERR and DECERR both have bit 1 set; OKAY and EXOKAY do not.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp & RESP_SLVERR) != RESP_OKAY;
    endfunction

endpackage

// File: rtl/srambus2axi_master.sv
// SRAM-like request bus (req/we/addr_ok/data_ok) to single-beat AXI3 master, one transaction outstanding.
// Ports: ACLK/ARESETn (sync, active-low); mem_* requester side; AW/W/B/AR/R AXI master channels.
// Latency: AXI valid at T+1 after acceptance, data_ok >= 3 cycles after acceptance; mem_addr_ok only in IDLE.
// Optional: define SRAM2AXI_RESP_ERR_EN to add output mem_err, pulsed with mem_data_ok on SLVERR/DECERR.
module srambus2axi_master
    import srambus2axi_master_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int MASTER_ID  = 0
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    // SRAM-like requester side
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [STRB_WIDTH-1:0] mem_wmask,
    output logic                  mem_addr_ok,
    output logic                  mem_data_ok,
    output logic [DATA_WIDTH-1:0] mem_rdata,
`ifdef SRAM2AXI_RESP_ERR_EN
    output logic                  mem_err,
`endif
    // AXI write address
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [3:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic [1:0]            AWBURST,
    output logic [ID_WIDTH-1:0]   AWID,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    // AXI write data
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic [STRB_WIDTH-1:0] WSTRB,
    output logic                  WLAST,
    output logic [ID_WIDTH-1:0]   WID,
    output logic                  WVALID,
    input  logic                  WREADY,
    // AXI write response
    input  logic [ID_WIDTH-1:0]   BID,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    // AXI read address
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [3:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic [1:0]            ARBURST,
    output logic [ID_WIDTH-1:0]   ARID,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    // AXI read data
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic [ID_WIDTH-1:0]   RID,
    input  logic                  RVALID,
    output logic                  RREADY
);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wmask_q, wmask_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    data_ok_q, data_ok_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
`ifdef SRAM2AXI_RESP_ERR_EN
    logic                    err_q, err_d;
`endif

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
`ifdef SRAM2AXI_RESP_ERR_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
`ifdef SRAM2AXI_RESP_ERR_EN
            err_q     <= err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        data_ok_d   = 1'b0;
        rdata_d     = rdata_q;
`ifdef SRAM2AXI_RESP_ERR_EN
        err_d       = 1'b0;
`endif
        mem_addr_ok = 1'b0;

        case (state_q)
            ST_IDLE: begin
                mem_addr_ok = mem_req;
                if (mem_req) begin
                    // Direction is carried by the next state, so mem_we needs no flop.
                    addr_d    = mem_address;
                    wdata_d   = mem_wdata;
                    wmask_d   = mem_wmask;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = mem_we ? ST_WR_REQ : ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                if (ARREADY) begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (RVALID) begin
                    rdata_d   = RDATA;
                    data_ok_d = 1'b1;
`ifdef SRAM2AXI_RESP_ERR_EN
                    err_d     = resp_is_err(RRESP);
`endif
                    state_d   = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                // AW and W complete independently, in either order or together.
                aw_done_d = aw_done_q | AWREADY;
                w_done_d  = w_done_q | WREADY;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (BVALID) begin
                    data_ok_d = 1'b1;
`ifdef SRAM2AXI_RESP_ERR_EN
                    err_d     = resp_is_err(BRESP);
`endif
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Valids/readies decode straight from state flops, so they are glitch-free
    // and drop on the same edge that a synchronous reset lands.
    assign ARVALID = (state_q == ST_RD_ADDR);
    assign RREADY  = (state_q == ST_RD_DATA);
    assign AWVALID = (state_q == ST_WR_REQ) && !aw_done_q;
    assign WVALID  = (state_q == ST_WR_REQ) && !w_done_q;
    assign BREADY  = (state_q == ST_WR_RESP);

    assign AWADDR  = addr_q;
    assign AWLEN   = 4'd0;
    assign AWSIZE  = SIZE_4B;
    assign AWBURST = BURST_INCR;
    assign AWID    = ID_WIDTH'(MASTER_ID);

    assign WDATA   = wdata_q;
    assign WSTRB   = wmask_q;
    assign WLAST   = 1'b1;
    assign WID     = ID_WIDTH'(MASTER_ID);

    assign ARADDR  = addr_q;
    assign ARLEN   = 4'd0;
    assign ARSIZE  = SIZE_4B;
    assign ARBURST = BURST_INCR;
    assign ARID    = ID_WIDTH'(MASTER_ID);

    assign mem_data_ok = data_ok_q;
    assign mem_rdata   = rdata_q;

`ifdef SRAM2AXI_RESP_ERR_EN
    assign mem_err = err_q;

    // Only the error bit of each response is meaningful here.
    logic unused_resp;
    assign unused_resp = ^{BID, BRESP[0], RID, RRESP[0], RLAST};
`else
    // Responses, IDs and RLAST carry no information for a single-beat, single-ID master.
    logic unused_resp;
    assign unused_resp = ^{BID, BRESP, RID, RRESP, RLAST};
`endif

endmodule

// File: tb/tb_srambus2axi_master.sv
module tb_srambus2axi_master;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        mem_req, mem_we;
    logic [31:0] mem_address, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
`ifdef SRAM2AXI_RESP_ERR_EN
    logic        mem_err;
`endif
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [3:0]  AWLEN, ARLEN, AWID, WID, ARID, BID, RID, WSTRB;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

    always #5 ACLK = ~ACLK;

    srambus2axi_master dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .mem_req(mem_req), .mem_we(mem_we), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
`ifdef SRAM2AXI_RESP_ERR_EN
        .mem_err(mem_err),
`endif
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWID(AWID),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WID(WID), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARID(ARID),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RID(RID), .RVALID(RVALID), .RREADY(RREADY)
    );

    // One record per clock cycle: inputs driven in that cycle, outputs expected in that cycle.
    // rdy = {AWREADY, WREADY, BVALID, ARREADY}
    // ectl = {mem_addr_ok, mem_data_ok, ARVALID, RREADY, AWVALID, WVALID, BREADY}
    typedef struct {
        logic        rst_n, req, we;
        logic [31:0] addr, wdata;
        logic [3:0]  wmask, rdy;
        logic        rv;
        logic [31:0] rdata;
        logic [6:0]  ectl;
        logic [31:0] erd, eaddr, ewd;
        logic [3:0]  ews;
    } vec_t;

    vec_t vecs[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    task automatic add(input logic rst_n, req, we, input logic [31:0] addr, wdata,
                       input logic [3:0] wmask, rdy, input logic rv, input logic [31:0] rdata,
                       input logic [6:0] ectl, input logic [31:0] erd, eaddr, ewd,
                       input logic [3:0] ews);
        vec_t v;
        v.rst_n = rst_n; v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
        v.wmask = wmask; v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.ectl = ectl;
        v.erd = erd; v.eaddr = eaddr; v.ewd = ewd; v.ews = ews;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic drive_quiet();
        mem_req = 0; mem_we = 0; mem_address = 0; mem_wdata = 0; mem_wmask = 0;
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
        RDATA = 0; RRESP = 0; BRESP = 0; BID = 0; RID = 0; RLAST = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int          ok_cnt;
        logic [31:0] got;

        // Read 0x100, zero-wait slave
        add(1,1,0,'h100,0,0,4'b0001,0,0,7'b1000000,0,0,0,0);
        add(1,0,0,0,0,0,4'b0001,0,0,7'b0010000,0,'h100,0,0);
        add(1,0,0,0,0,0,4'b0000,1,'hDEADBEEF,7'b0001000,0,0,0,0);
        add(1,0,0,0,0,0,0,0,0,7'b0100000,'hDEADBEEF,0,0,0);
        // Write 0x200, W accepted first, AW three cycles later
        add(1,1,1,'h200,'h12345678,4'b0011,0,0,0,7'b1000000,'hDEADBEEF,0,0,0);
        add(1,0,0,0,0,0,4'b0100,0,0,7'b0000110,'hDEADBEEF,'h200,'h12345678,4'b0011);
        add(1,0,0,0,0,0,4'b0000,0,0,7'b0000100,'hDEADBEEF,'h200,0,0);
        add(1,0,0,0,0,0,4'b0000,0,0,7'b0000100,'hDEADBEEF,'h200,0,0);
        add(1,0,0,0,0,0,4'b1000,0,0,7'b0000100,'hDEADBEEF,'h200,0,0);
        add(1,0,0,0,0,0,4'b0010,0,0,7'b0000001,'hDEADBEEF,0,0,0);
        add(1,0,0,0,0,0,0,0,0,7'b0100000,'hDEADBEEF,0,0,0);
        add(1,0,0,0,0,0,0,0,0,7'b0000000,'hDEADBEEF,0,0,0);
        // Backpressured read 0x400 with a second request 0x500 held pending
        add(1,1,0,'h400,0,0,0,0,0,7'b1000000,'hDEADBEEF,0,0,0);
        for (int i = 0; i < 5; i++)
            add(1,1,0,'h500,0,0,0,0,0,7'b0010000,'hDEADBEEF,'h400,0,0);
        add(1,1,0,'h500,0,0,4'b0001,0,0,7'b0010000,'hDEADBEEF,'h400,0,0);
        for (int i = 0; i < 4; i++)
            add(1,1,0,'h500,0,0,0,0,0,7'b0001000,'hDEADBEEF,0,0,0);
        add(1,1,0,'h500,0,0,0,1,'hCAFEF00D,7'b0001000,'hDEADBEEF,0,0,0);
        add(1,1,0,'h500,0,0,0,0,0,7'b1100000,'hCAFEF00D,0,0,0);
        add(1,0,0,0,0,0,4'b0001,0,0,7'b0010000,'hCAFEF00D,'h500,0,0);
        add(1,0,0,0,0,0,0,1,'h55,7'b0001000,'hCAFEF00D,0,0,0);
        add(1,0,0,0,0,0,0,0,0,7'b0100000,'h55,0,0,0);
        // Back-to-back: write 0x300, read 0x300 held and accepted with write's data_ok
        add(1,1,1,'h300,'hA5A5A5A5,4'hF,0,0,0,7'b1000000,'h55,0,0,0);
        add(1,1,0,'h300,0,0,4'b1100,0,0,7'b0000110,'h55,'h300,'hA5A5A5A5,4'hF);
        add(1,1,0,'h300,0,0,4'b0010,0,0,7'b0000001,'h55,0,0,0);
        add(1,1,0,'h300,0,0,0,0,0,7'b1100000,'h55,0,0,0);
        add(1,0,0,0,0,0,4'b0001,0,0,7'b0010000,'h55,'h300,0,0);
        add(1,0,0,0,0,0,0,1,'hA5A5A5A5,7'b0001000,'h55,0,0,0);
        add(1,0,0,0,0,0,0,0,0,7'b0100000,'hA5A5A5A5,0,0,0);
        // Reset while in RD_DATA, then a normal read
        add(1,1,0,'h600,0,0,0,0,0,7'b1000000,'hA5A5A5A5,0,0,0);
        add(1,0,0,0,0,0,4'b0001,0,0,7'b0010000,'hA5A5A5A5,'h600,0,0);
        add(0,0,0,0,0,0,0,0,0,7'b0001000,'hA5A5A5A5,0,0,0);
        add(1,0,0,0,0,0,0,0,0,7'b0000000,0,0,0,0);
        add(1,0,0,0,0,0,0,0,0,7'b0000000,0,0,0,0);
        add(1,1,0,'h700,0,0,0,0,0,7'b1000000,0,0,0,0);
        add(1,0,0,0,0,0,4'b0001,0,0,7'b0010000,0,'h700,0,0);
        add(1,0,0,0,0,0,0,1,'h77,7'b0001000,0,0,0,0);
        add(1,0,0,0,0,0,0,0,0,7'b0100000,'h77,0,0,0);
        // Write 0x800, AW first, W stalled two cycles, B delayed one
        add(1,1,1,'h800,'h11223344,4'hC,0,0,0,7'b1000000,'h77,0,0,0);
        add(1,0,0,0,0,0,4'b1000,0,0,7'b0000110,'h77,'h800,'h11223344,4'hC);
        add(1,0,0,0,0,0,4'b0000,0,0,7'b0000010,'h77,0,'h11223344,4'hC);
        add(1,0,0,0,0,0,4'b0100,0,0,7'b0000010,'h77,0,'h11223344,4'hC);
        add(1,0,0,0,0,0,4'b0000,0,0,7'b0000001,'h77,0,0,0);
        add(1,0,0,0,0,0,4'b0010,0,0,7'b0000001,'h77,0,0,0);
        add(1,0,0,0,0,0,0,0,0,7'b0100000,'h77,0,0,0);

        // Reset state
        drive_quiet();
        ARESETn = 0;
        repeat (3) @(posedge ACLK);
        #1;
        check("reset_ctl", {mem_addr_ok, mem_data_ok, ARVALID, RREADY, AWVALID, WVALID, BREADY}, 0);
        check("reset_rdata", mem_rdata, 0);
        check("reset_latched", {AWADDR, WDATA, WSTRB}, 0);

        foreach (vecs[i]) begin
            ARESETn     = vecs[i].rst_n;
            mem_req     = vecs[i].req;
            mem_we      = vecs[i].we;
            mem_address = vecs[i].addr;
            mem_wdata   = vecs[i].wdata;
            mem_wmask   = vecs[i].wmask;
            {AWREADY, WREADY, BVALID, ARREADY} = vecs[i].rdy;
            RVALID      = vecs[i].rv;
            RDATA       = vecs[i].rdata;
            @(negedge ACLK);
            check($sformatf("row%0d_ctl", i),
                  {mem_addr_ok, mem_data_ok, ARVALID, RREADY, AWVALID, WVALID, BREADY}, vecs[i].ectl);
            check($sformatf("row%0d_rdata", i), mem_rdata, vecs[i].erd);
            if (vecs[i].ectl[4])
                check($sformatf("row%0d_ar", i), {ARLEN, ARSIZE, ARBURST, ARID, ARADDR},
                      {4'd0, 3'b010, 2'b01, 4'd0, vecs[i].eaddr});
            if (vecs[i].ectl[2])
                check($sformatf("row%0d_aw", i), {AWLEN, AWSIZE, AWBURST, AWID, AWADDR},
                      {4'd0, 3'b010, 2'b01, 4'd0, vecs[i].eaddr});
            if (vecs[i].ectl[1])
                check($sformatf("row%0d_w", i), {WDATA, WSTRB, WLAST, WID},
                      {vecs[i].ewd, vecs[i].ews, 1'b1, 4'd0});
            @(posedge ACLK);
            #1;
        end

        // Reactive slave with slow ready/valid; bounded wait for exactly one data_ok
        drive_quiet();
        mem_req = 1; mem_address = 'hA00;
        @(negedge ACLK);
        check("hs_addr_ok", mem_addr_ok, 1);
        @(posedge ACLK);
        #1;
        mem_req = 0;
        ok_cnt = 0;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            ARREADY = ARVALID && (c >= 2);
            RVALID  = RREADY && (c >= 6);
            RDATA   = 'h0A0A0A0A;
            @(negedge ACLK);
            if (mem_data_ok) begin
                ok_cnt++;
                got = mem_rdata;
            end
            @(posedge ACLK);
            #1;
        end
        drive_quiet();
        check("hs_data_ok_count", ok_cnt, 1);
        check("hs_rdata", got, 'h0A0A0A0A);

`ifdef SRAM2AXI_RESP_ERR_EN
        // Write answered with SLVERR
        mem_req = 1; mem_we = 1; mem_address = 'h40; mem_wdata = 'h1; mem_wmask = 4'hF;
        @(posedge ACLK); #1;
        drive_quiet();
        AWREADY = 1; WREADY = 1;
        @(posedge ACLK); #1;
        drive_quiet();
        BVALID = 1; BRESP = 2'b10;
        @(posedge ACLK); #1;
        drive_quiet();
        @(negedge ACLK);
        check("err_bresp_slverr", {mem_data_ok, mem_err}, 2'b11);
        @(posedge ACLK); #1;
        // Read answered with OKAY
        mem_req = 1; mem_we = 0; mem_address = 'h44;
        @(posedge ACLK); #1;
        drive_quiet();
        ARREADY = 1;
        @(posedge ACLK); #1;
        drive_quiet();
        RVALID = 1; RRESP = 2'b00; RDATA = 'h99;
        @(posedge ACLK); #1;
        drive_quiet();
        @(negedge ACLK);
        check("err_rresp_okay", {mem_data_ok, mem_err}, 2'b10);
        @(posedge ACLK); #1;
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
